// File: rtl/irq_ctrl.sv
// Interrupt controller: samples peripheral request levels, optionally edge-latches and masks
// them, and presents the highest-index active source to the CPU as a registered line + vector.
module irq_ctrl #(
    parameter int unsigned NUM_SRC = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_en,
    input  logic               i_wr,
    input  logic [1:0]         i_addr,
    input  logic [31:0]        i_data_in,
    output logic [31:0]        o_data_out,
    output logic               o_wt,
    input  logic [NUM_SRC-1:0] i_irq_in,
    output logic               o_cpu_irq,
    output logic [4:0]         o_vec_num
);

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_EDGE    = 2'd2;
    localparam logic [1:0] ADDR_VECTOR  = 2'd3;

    logic [NUM_SRC-1:0] r_irq_q;
    logic [NUM_SRC-1:0] r_irq_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_edge;
    logic               r_cpu_irq;
    logic [4:0]         r_vec_num;
    logic               r_valid;

    logic               w_wr;
    logic [NUM_SRC-1:0] w_wr_data;
    logic [NUM_SRC-1:0] w_pend_clr;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_pending_d;
    logic [NUM_SRC-1:0] w_active;
    logic [4:0]         w_vec;

    assign w_wr       = i_en & i_wr;
    assign w_wr_data  = i_data_in[NUM_SRC-1:0];
    assign w_pend_clr = (w_wr && (i_addr == ADDR_PENDING)) ? w_wr_data : '0;
    assign w_rise     = r_irq_q & ~r_irq_prev;
    assign w_active   = r_pending & r_mask;

    // Edge-mode bits: a new rising edge beats a simultaneous write-clear.
    assign w_pending_d = (r_irq_q & ~r_edge)
                       | (r_edge & (w_rise | (r_pending & ~w_pend_clr)));

    always_comb begin
        w_vec = 5'd0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (w_active[i]) begin
                w_vec = 5'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_irq_q    <= '0;
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
            r_edge     <= '0;
            r_cpu_irq  <= 1'b0;
            r_vec_num  <= 5'd0;
            r_valid    <= 1'b0;
        end else begin
            r_irq_q    <= i_irq_in;
            r_irq_prev <= r_irq_q;
            r_pending  <= w_pending_d;
            r_cpu_irq  <= |w_active;
            r_vec_num  <= w_vec;
            r_valid    <= |w_active;
            if (w_wr && (i_addr == ADDR_MASK)) begin
                r_mask <= w_wr_data;
            end
            if (w_wr && (i_addr == ADDR_EDGE)) begin
                r_edge <= w_wr_data;
            end
        end
    end

    always_comb begin
        o_data_out = 32'd0;
        case (i_addr)
            ADDR_PENDING: o_data_out = 32'(r_pending);
            ADDR_MASK:    o_data_out = 32'(r_mask);
            ADDR_EDGE:    o_data_out = 32'(r_edge);
            ADDR_VECTOR:  o_data_out = {r_valid, 26'd0, r_vec_num};
            default:      o_data_out = 32'd0;
        endcase
    end

    assign o_wt      = 1'b0;
    assign o_cpu_irq = r_cpu_irq;
    assign o_vec_num = r_vec_num;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus a randomized run against a
// per-edge reference model of the controller's registers.
module tb_irq_ctrl;

    localparam int unsigned NSRC = 16;
    localparam logic [31:0] SRC_MASK = 32'h0000_FFFF;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            wr;
    logic [1:0]      addr;
    logic [31:0]     din;
    logic [31:0]     dout;
    logic            wt;
    logic [NSRC-1:0] irq;
    logic            cpu_irq;
    logic [4:0]      vec_num;

    int total = 0;
    int bad   = 0;

    // Reference model state (32-bit words, only low NSRC bits meaningful).
    logic [31:0] m_q, m_prev, m_pend, m_mask, m_edge;
    logic        m_cpu;
    logic [4:0]  m_vec;

    irq_ctrl #(.NUM_SRC(NSRC)) u_dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_en       (en),
        .i_wr       (wr),
        .i_addr     (addr),
        .i_data_in  (din),
        .o_data_out (dout),
        .o_wt       (wt),
        .i_irq_in   (irq),
        .o_cpu_irq  (cpu_irq),
        .o_vec_num  (vec_num)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] highest(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return 5'(i);
        end
        return 5'd0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_pend;
            2'd1:    return m_mask;
            2'd2:    return m_edge;
            default: return {m_cpu, 26'd0, m_vec};
        endcase
    endfunction

    // One rising edge: model consumes the inputs present before the edge.
    task automatic tick();
        logic        c_rst, c_wrt;
        logic [1:0]  c_addr;
        logic [31:0] c_din, c_irq, rise, clr, act;
        c_rst  = rst_n;
        c_wrt  = en & wr;
        c_addr = addr;
        c_din  = din & SRC_MASK;
        c_irq  = 32'(irq);
        @(posedge clk);
        if (!c_rst) begin
            m_q = 0; m_prev = 0; m_pend = 0; m_mask = 0; m_edge = 0; m_cpu = 0; m_vec = 0;
        end else begin
            rise   = m_q & ~m_prev;
            clr    = (c_wrt && c_addr == 2'd0) ? c_din : 32'd0;
            act    = m_pend & m_mask;
            m_cpu  = (act != 0);
            m_vec  = highest(act);
            m_pend = (m_q & ~m_edge) | (m_edge & (rise | (m_pend & ~clr)));
            if (c_wrt && c_addr == 2'd1) m_mask = c_din;
            if (c_wrt && c_addr == 2'd2) m_edge = c_din;
            m_prev = m_q;
            m_q    = c_irq;
        end
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        en = 1'b1; wr = 1'b1; addr = a; din = d;
        tick();
        en = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] v);
        en = 1'b1; wr = 1'b0; addr = a;
        #1;
        v = dout;
        en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst_n = 1'b0;
        en = 1'b1; wr = 1'b1; addr = 2'd1; din = 32'hFFFF;
        tick();
        tick();
        en = 1'b0; wr = 1'b0;
        rst_n = 1'b1;
        bus_rd(2'd1, v);
        total++;
        if (v !== 32'd0) begin bad++; $display("FAIL reset_mask: got %h want 0", v); end
        total++;
        if (cpu_irq !== 1'b0) begin bad++; $display("FAIL reset_cpu: got %b want 0", cpu_irq); end
        bus_rd(2'd3, v);
        total++;
        if (v !== 32'd0) begin bad++; $display("FAIL reset_vector: got %h want 0", v); end
    endtask

    task automatic test_level();
        logic [31:0] v;
        bus_wr(2'd2, 32'h0);
        bus_wr(2'd1, 32'h4000);
        irq[14] = 1'b1;
        tick();
        tick();
        total++;
        if (cpu_irq !== 1'b0) begin bad++; $display("FAIL level_early: got %b want 0", cpu_irq); end
        tick();
        total++;
        if (cpu_irq !== 1'b1 || vec_num !== 5'd14) begin
            bad++; $display("FAIL level_raise: got cpu=%b vec=%0d want cpu=1 vec=14", cpu_irq, vec_num);
        end
        bus_rd(2'd3, v);
        total++;
        if (v !== 32'h8000000E) begin bad++; $display("FAIL level_vector: got %h want 8000000e", v); end
        irq[14] = 1'b0;
        tick();
        tick();
        total++;
        if (cpu_irq !== 1'b1) begin bad++; $display("FAIL level_hold: got %b want 1", cpu_irq); end
        tick();
        total++;
        if (cpu_irq !== 1'b0) begin bad++; $display("FAIL level_drop: got %b want 0", cpu_irq); end
    endtask

    task automatic test_edge();
        logic [31:0] v;
        bus_wr(2'd2, 32'h0008);
        bus_wr(2'd1, 32'h0008);
        irq[3] = 1'b1;
        tick();
        irq[3] = 1'b0;
        repeat (5) tick();
        bus_rd(2'd0, v);
        total++;
        if (v !== 32'h0008) begin bad++; $display("FAIL edge_latch: got %h want 00000008", v); end
        total++;
        if (cpu_irq !== 1'b1 || vec_num !== 5'd3) begin
            bad++; $display("FAIL edge_cpu: got cpu=%b vec=%0d want cpu=1 vec=3", cpu_irq, vec_num);
        end
        bus_wr(2'd0, 32'h0008);
        bus_rd(2'd0, v);
        total++;
        if (v !== 32'd0) begin bad++; $display("FAIL edge_clear: got %h want 0", v); end
        total++;
        if (cpu_irq !== 1'b1) begin bad++; $display("FAIL edge_cpu_lag: got %b want 1", cpu_irq); end
        tick();
        total++;
        if (cpu_irq !== 1'b0) begin bad++; $display("FAIL edge_cpu_fall: got %b want 0", cpu_irq); end
    endtask

    task automatic test_priority();
        logic [31:0] v;
        bus_wr(2'd1, 32'h0204);
        bus_wr(2'd2, 32'h0);
        irq[2] = 1'b1;
        irq[9] = 1'b1;
        repeat (4) tick();
        total++;
        if (vec_num !== 5'd9) begin bad++; $display("FAIL prio_high: got %0d want 9", vec_num); end
        bus_wr(2'd1, 32'h0004);
        tick();
        total++;
        if (vec_num !== 5'd2 || cpu_irq !== 1'b1) begin
            bad++; $display("FAIL prio_masked: got cpu=%b vec=%0d want cpu=1 vec=2", cpu_irq, vec_num);
        end
        bus_rd(2'd0, v);
        total++;
        if (v !== 32'h0204) begin bad++; $display("FAIL prio_pending: got %h want 00000204", v); end
        irq = '0;
        repeat (3) tick();
    endtask

    task automatic test_collision();
        logic [31:0] v;
        bus_wr(2'd2, 32'h0020);
        bus_wr(2'd1, 32'h0020);
        bus_wr(2'd0, 32'hFFFF);
        irq[5] = 1'b1;
        tick();
        // irq_q[5]=1, irq_prev[5]=0 at this write edge
        bus_wr(2'd0, 32'h0020);
        bus_rd(2'd0, v);
        total++;
        if (v[5] !== 1'b1) begin bad++; $display("FAIL collide_set_wins: got %b want 1", v[5]); end
        bus_wr(2'd0, 32'h0020);
        bus_rd(2'd0, v);
        total++;
        if (v[5] !== 1'b0) begin bad++; $display("FAIL collide_reclear: got %b want 0", v[5]); end
        irq[5] = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_held();
        logic [31:0] v;
        bus_wr(2'd2, 32'h0002);
        bus_wr(2'd1, 32'h0002);
        bus_wr(2'd0, 32'hFFFF);
        irq[1] = 1'b1;
        repeat (3) tick();
        bus_rd(2'd0, v);
        total++;
        if (v[1] !== 1'b1) begin bad++; $display("FAIL held_event: got %b want 1", v[1]); end
        bus_wr(2'd0, 32'h0002);
        for (int i = 0; i < 6; i++) begin
            tick();
            bus_rd(2'd0, v);
            total++;
            if (v[1] !== 1'b0) begin bad++; $display("FAIL held_no_retrig[%0d]: got %b want 0", i, v[1]); end
        end
        irq[1] = 1'b0;
        tick();
        irq[1] = 1'b1;
        repeat (2) tick();
        bus_rd(2'd0, v);
        total++;
        if (v[1] !== 1'b1) begin bad++; $display("FAIL held_retrig: got %b want 1", v[1]); end
        irq[1] = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] exp_rd;
        for (int n = 0; n < 600; n++) begin
            // Sparse toggling so edge events and holds both occur.
            irq  = irq ^ NSRC'($urandom & $urandom & $urandom);
            en   = ($urandom_range(0, 2) == 0);
            wr   = $urandom_range(0, 1) == 1;
            addr = 2'($urandom_range(0, 3));
            din  = $urandom;
            rst_n = ($urandom_range(0, 199) != 0);
            #1;
            if (en && !wr) begin
                exp_rd = model_read(addr);
                total++;
                if (dout !== exp_rd) begin
                    bad++; $display("FAIL rand_read[%0d] addr=%0d: got %h want %h", n, addr, dout, exp_rd);
                end
            end
            tick();
            total++;
            if (cpu_irq !== m_cpu || vec_num !== m_vec || wt !== 1'b0) begin
                bad++;
                $display("FAIL rand_out[%0d]: got cpu=%b vec=%0d wt=%b want cpu=%b vec=%0d wt=0",
                         n, cpu_irq, vec_num, wt, m_cpu, m_vec);
            end
        end
        en = 1'b0; wr = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; wr = 1'b0; addr = 2'd0; din = 32'd0; irq = '0;
        m_q = 0; m_prev = 0; m_pend = 0; m_mask = 0; m_edge = 0; m_cpu = 0; m_vec = 0;
        #1;
        test_reset();
        test_level();
        test_edge();
        test_priority();
        test_collision();
        test_held();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
